// File: rtl/branch_history_predictor.sv
// Bimodal branch predictor: PC-indexed saturating counters, combinational prediction,
// index-based training and saturating perf counters. Define BHP_GSHARE_EN to XOR a global history into the index.
module branch_history_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 6,
    parameter int CNT_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           fetch_pc,
    output logic                  predict_taken,
    output logic [INDEX_BITS-1:0] predict_idx,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_idx,
    input  logic                  update_taken,
    input  logic                  update_pred_taken,
    output logic [CNT_BITS-1:0]   branch_cnt,
    output logic [CNT_BITS-1:0]   mispredict_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CTR_BITS-1:0]   table_q [ENTRIES];
    logic [CTR_BITS-1:0]   table_d [ENTRIES];
    logic [CTR_BITS-1:0]   upd_old;
    logic [CTR_BITS-1:0]   upd_new;
    logic [CNT_BITS-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_BITS-1:0]   mispredict_cnt_q, mispredict_cnt_d;
    logic [INDEX_BITS-1:0] base_idx;

    assign base_idx = fetch_pc[INDEX_BITS+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0]};

`ifdef BHP_GSHARE_EN
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [HIST_BITS:0]   ghr_shift;
    logic                 unused_ghr_msb;

    // Shift through a one-bit-wider vector so HIST_BITS=1 needs no special case.
    always_comb begin
        ghr_shift = {ghr_q, update_taken};
        ghr_d     = ghr_q;
        if (update_valid) begin
            ghr_d = ghr_shift[HIST_BITS-1:0];
        end
    end

    assign unused_ghr_msb = ghr_shift[HIST_BITS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign predict_idx = base_idx ^ INDEX_BITS'(ghr_q);
`else
    logic unused_hist;
    assign unused_hist = (HIST_BITS > INDEX_BITS);

    assign predict_idx = base_idx;
`endif

    // Read of the current table state: a same-cycle update is not bypassed.
    assign predict_taken = table_q[predict_idx][CTR_BITS-1];

    always_comb begin
        upd_old = table_q[update_idx];
        upd_new = upd_old;
        if (update_taken) begin
            if (upd_old != CTR_MAX) begin
                upd_new = upd_old + CTR_BITS'(1);
            end
        end else begin
            if (upd_old != '0) begin
                upd_new = upd_old - CTR_BITS'(1);
            end
        end
    end

    always_comb begin
        table_d = table_q;
        if (update_valid) begin
            table_d[update_idx] = upd_new;
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (update_valid) begin
            if (branch_cnt_q != CNT_MAX) begin
                branch_cnt_d = branch_cnt_q + CNT_BITS'(1);
            end
            if ((update_taken != update_pred_taken) && (mispredict_cnt_q != CNT_MAX)) begin
                mispredict_cnt_d = mispredict_cnt_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_WNT;
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            table_q          <= table_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed self-checking bench for branch_history_predictor (INDEX_BITS=6, CTR_BITS=2, HIST_BITS=2);
// a second instance with CNT_BITS=4 checks counter saturation.
module tb_branch_history_predictor;

    logic        clk;
    logic        reset_n;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [5:0]  predict_idx;
    logic        update_valid;
    logic [5:0]  update_idx;
    logic        update_taken;
    logic        update_pred_taken;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    logic        s_predict_taken;
    logic [5:0]  s_predict_idx;
    logic [3:0]  s_branch_cnt;
    logic [3:0]  s_mispredict_cnt;

    int total;
    int bad;

    branch_history_predictor #(
        .INDEX_BITS(6), .CTR_BITS(2), .HIST_BITS(2), .CNT_BITS(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
        .predict_taken(predict_taken), .predict_idx(predict_idx),
        .update_valid(update_valid), .update_idx(update_idx),
        .update_taken(update_taken), .update_pred_taken(update_pred_taken),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_history_predictor #(
        .INDEX_BITS(6), .CTR_BITS(2), .HIST_BITS(2), .CNT_BITS(4)
    ) dut_small (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
        .predict_taken(s_predict_taken), .predict_idx(s_predict_idx),
        .update_valid(update_valid), .update_idx(update_idx),
        .update_taken(update_taken), .update_pred_taken(update_pred_taken),
        .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One update on the next rising edge; returns 1 time unit after that edge.
    task automatic upd(input logic [5:0] idx, input logic t, input logic p);
        update_valid      = 1'b1;
        update_idx        = idx;
        update_taken      = t;
        update_pred_taken = p;
        @(posedge clk);
        #1;
        update_valid      = 1'b0;
        $display("update idx=%0d taken=%0b pred=%0b", idx, t, p);
    endtask

    // Assert reset between edges and confirm state clears without any clock edge.
    task automatic do_reset(input string tag);
        reset_n  = 1'b0;
        fetch_pc = 32'h14;
        #2;
        total++;
        if (predict_taken !== 1'b0) begin
            bad++;
            $display("FAIL %s_pred actual=%0b required=0", tag, predict_taken);
        end
        total++;
        if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin
            bad++;
            $display("FAIL %s_cnt actual=%0d/%0d required=0/0", tag, branch_cnt, mispredict_cnt);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset %s done", tag);
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc,
                              input logic exp_t, input logic [5:0] exp_idx);
        fetch_pc = pc;
        #1;
        total++;
        if (predict_taken !== exp_t || predict_idx !== exp_idx) begin
            bad++;
            $display("FAIL %s pc=%h actual=%0b/idx%0d required=%0b/idx%0d",
                     name, pc, predict_taken, predict_idx, exp_t, exp_idx);
        end else begin
            $display("check %s pc=%h taken=%0b idx=%0d", name, pc, predict_taken, predict_idx);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #2;
        for (int pc = 0; pc <= 'hFC; pc += 4) begin
            fetch_pc = 32'(pc);
            #1;
            total++;
            if (predict_taken !== 1'b0 || predict_idx !== 6'(pc >> 2)) begin
                bad++;
                $display("FAIL reset_pred pc=%h actual=%0b/idx%0d required=0/idx%0d",
                         pc, predict_taken, predict_idx, pc >> 2);
            end
        end
        total++;
        if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0 ||
            s_branch_cnt !== 4'd0 || s_mispredict_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_cnt actual=%0d/%0d required=0/0", branch_cnt, mispredict_cnt);
        end
        $display("reset scan done");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation;
        logic exp_up [4];
        logic exp_dn [4];
        exp_up = '{1'b1, 1'b1, 1'b1, 1'b1};
        exp_dn = '{1'b1, 1'b0, 1'b0, 1'b0};
        do_reset("sat");
        for (int i = 0; i < 4; i++) begin
            upd(6'd5, 1'b1, 1'b0);
            check_pred("sat_up", 32'h14, exp_up[i], 6'd5);
        end
        for (int i = 0; i < 4; i++) begin
            upd(6'd5, 1'b0, 1'b1);
            check_pred("sat_down", 32'h14, exp_dn[i], 6'd5);
        end
        // Counter must sit at 0: one taken step only reaches 1.
        upd(6'd5, 1'b1, 1'b0);
        check_pred("sat_floor", 32'h14, 1'b0, 6'd5);
    endtask

    task automatic test_alias;
        do_reset("alias");
        upd(6'd5, 1'b1, 1'b0);
        upd(6'd5, 1'b1, 1'b0);
        check_pred("alias_114", 32'h114, 1'b1, 6'd5);
        check_pred("alias_neighbour", 32'h18, 1'b0, 6'd6);
    endtask

    task automatic test_hazard;
        do_reset("hazard");
        fetch_pc          = 32'h14;
        update_valid      = 1'b1;
        update_idx        = 6'd5;
        update_taken      = 1'b1;
        update_pred_taken = 1'b0;
        #1;
        total++;
        if (predict_taken !== 1'b0) begin
            bad++;
            $display("FAIL hazard_same_cycle actual=%0b required=0", predict_taken);
        end
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        total++;
        if (predict_taken !== 1'b1) begin
            bad++;
            $display("FAIL hazard_next_cycle actual=%0b required=1", predict_taken);
        end
        $display("hazard same=0 next=%0b", predict_taken);
    endtask

    task automatic test_back_to_back;
        do_reset("b2b");
        update_valid      = 1'b1;
        update_pred_taken = 1'b1;
        update_idx = 6'd1; update_taken = 1'b1; @(posedge clk); #1;
        update_idx = 6'd2; update_taken = 1'b1; @(posedge clk); #1;
        update_idx = 6'd2; update_taken = 1'b1; @(posedge clk); #1;
        update_idx = 6'd1; update_taken = 1'b0; @(posedge clk); #1;
        update_idx = 6'd2; update_taken = 1'b0; @(posedge clk); #1;
        update_valid = 1'b0;
        // idx1: 1->2->1, idx2: 1->2->3->2
        check_pred("b2b_idx1", 32'h4, 1'b0, 6'd1);
        check_pred("b2b_idx2", 32'h8, 1'b1, 6'd2);
        total++;
        if (branch_cnt !== 32'd5 || mispredict_cnt !== 32'd2) begin
            bad++;
            $display("FAIL b2b_cnt actual=%0d/%0d required=5/2", branch_cnt, mispredict_cnt);
        end
    endtask

    task automatic test_idle;
        // Continues from back-to-back state; update fields toggle with valid low.
        update_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            update_idx        = 6'd2;
            update_taken      = i[0];
            update_pred_taken = ~i[0];
            @(posedge clk);
            #1;
        end
        check_pred("idle_idx2", 32'h8, 1'b1, 6'd2);
        check_pred("idle_idx1", 32'h4, 1'b0, 6'd1);
        total++;
        if (branch_cnt !== 32'd5 || mispredict_cnt !== 32'd2) begin
            bad++;
            $display("FAIL idle_cnt actual=%0d/%0d required=5/2", branch_cnt, mispredict_cnt);
        end
    endtask

    task automatic test_counters;
        logic t_vec [10];
        logic p_vec [10];
        t_vec = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        p_vec = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset("cnt");
        for (int i = 0; i < 10; i++) begin
            upd(6'(i), t_vec[i], p_vec[i]);
        end
        total++;
        if (branch_cnt !== 32'd10 || mispredict_cnt !== 32'd3) begin
            bad++;
            $display("FAIL cnt_10 actual=%0d/%0d required=10/3", branch_cnt, mispredict_cnt);
        end
        total++;
        if (s_branch_cnt !== 4'd10 || s_mispredict_cnt !== 4'd3) begin
            bad++;
            $display("FAIL cnt4_10 actual=%0d/%0d required=10/3", s_branch_cnt, s_mispredict_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            upd(6'd20, 1'b1, 1'b1);
        end
        total++;
        if (branch_cnt !== 32'd20 || mispredict_cnt !== 32'd3) begin
            bad++;
            $display("FAIL cnt_20 actual=%0d/%0d required=20/3", branch_cnt, mispredict_cnt);
        end
        total++;
        if (s_branch_cnt !== 4'd15 || s_mispredict_cnt !== 4'd3) begin
            bad++;
            $display("FAIL cnt4_sat actual=%0d/%0d required=15/3", s_branch_cnt, s_mispredict_cnt);
        end
        $display("counters branch=%0d mis=%0d small_branch=%0d", branch_cnt, mispredict_cnt, s_branch_cnt);
    endtask

`ifdef BHP_GSHARE_EN
    task automatic test_gshare;
        do_reset("gshare");
        check_pred("gs_reset_idx", 32'h14, 1'b0, 6'd5);
        upd(6'd0, 1'b1, 1'b1);
        upd(6'd0, 1'b0, 1'b0);
        // ghr=2'b10 -> 5 ^ 2 = 7
        check_pred("gs_idx", 32'h14, 1'b0, 6'h07);
        update_valid      = 1'b1;
        update_idx        = 6'd0;
        update_taken      = 1'b1;
        update_pred_taken = 1'b1;
        #1;
        total++;
        if (predict_idx !== 6'h07) begin
            bad++;
            $display("FAIL gs_preshift actual=%0d required=7", predict_idx);
        end
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        // ghr=2'b01 -> 5 ^ 1 = 4
        total++;
        if (predict_idx !== 6'h04) begin
            bad++;
            $display("FAIL gs_postshift actual=%0d required=4", predict_idx);
        end
        $display("gshare idx=%0d", predict_idx);
    endtask
`endif

    initial begin
        total             = 0;
        bad               = 0;
        reset_n           = 1'b0;
        fetch_pc          = 32'h0;
        update_valid      = 1'b0;
        update_idx        = 6'd0;
        update_taken      = 1'b0;
        update_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
`ifdef BHP_GSHARE_EN
        test_gshare;
`else
        test_saturation;
        test_alias;
        test_hazard;
        test_back_to_back;
        test_idle;
`endif
        test_counters;
        do_reset("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_history_predictor.md
# branch_history_predictor

PC-indexed table of parametrised saturating counters (bimodal), with an optional global-history XOR (gshare) index. Sits beside the fetch stage. It returns a taken/not-taken prediction for the fetch PC in the same cycle, plus the table index used. The pipeline carries that index to execute and returns it with the resolved outcome to train the entry. It also keeps saturating branch and misprediction counters for performance monitoring.

## Interface
- INDEX_BITS, 6: table has 2^INDEX_BITS entries; legal 2..12.
- CTR_BITS, 2: counter width; legal 1..4.
- HIST_BITS, 6: global history length; legal 1..INDEX_BITS; used only with gshare.
- CNT_BITS, 32: width of the performance counters.

- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_pc  in  32  PC of the instruction in fetch.
- predict_taken  out  1  prediction for fetch_pc.
- predict_idx  out  INDEX_BITS  table index used for this prediction.
- update_valid  in  1  resolved conditional branch this cycle.
- update_idx  in  INDEX_BITS  predict_idx carried down from fetch.
- update_taken  in  1  actual outcome.
- update_pred_taken  in  1  prediction that was used for this branch.
- branch_cnt  out  CNT_BITS  resolved branches since reset.
- mispredict_cnt  out  CNT_BITS  mispredictions since reset.

## Operation
- Index computation:
  - Base index is fetch_pc[INDEX_BITS+1:2]; PC bits [1:0] are ignored.
  - With gshare, predict_idx = base XOR {zero-extend(ghr)}, where ghr occupies the low HIST_BITS.
- Counter table:
  - Each entry is an unsigned CTR_BITS counter.
  - Reset value of every entry is WNT = 2^(CTR_BITS-1)-1 (01 for 2 bits; 0 for 1 bit).
- Prediction: predict_taken = MSB of the entry at predict_idx.
- Update, on a cycle with update_valid=1:
  - Entry update_idx increments if update_taken=1, saturating at 2^CTR_BITS-1.
  - Entry update_idx decrements if update_taken=0, saturating at 0.
  - Training always uses update_idx. The PC is never re-hashed at update time.
- Global history (gshare only):
  - ghr[HIST_BITS-1:0] resets to 0.
  - On update_valid: ghr <= {ghr[HIST_BITS-2:0], update_taken} (for HIST_BITS=1, ghr <= update_taken).
  - History is non-speculative: it is updated only at resolution.
- Performance counters:
  - On update_valid, branch_cnt increments.
  - mispredict_cnt increments when update_taken != update_pred_taken.
  - Both saturate at all-ones.
- With update_valid=0, no state changes.

## Timing
- Prediction is combinational: fetch_pc -> predict_taken/predict_idx settle in the same cycle. There are no registers on the path.
- An update becomes visible to predictions from the cycle after the update edge.
- Same-cycle read and write of the same index: the prediction returns the pre-update value. There is no bypass.
- An update and a gshare prediction in the same cycle: the prediction uses the pre-shift ghr.
- Reset values, with reset_n low regardless of clk:
  - predict_taken = 0, since all entries are WNT.
  - ghr = 0, branch_cnt = 0, mispredict_cnt = 0.
- Reset asserted mid-operation clears all state immediately. The first update after release occurs on the first rising edge with reset_n=1.
- Update latency is one edge; back-to-back updates are accepted every cycle.

## Configuration
- BHP_GSHARE_EN defined:
  - ghr is instantiated and XORed into the index, as above.
  - HIST_BITS is legal only in this mode.
- BHP_GSHARE_EN undefined:
  - Pure bimodal: predict_idx = fetch_pc[INDEX_BITS+1:2].
  - No ghr flops; HIST_BITS is ignored.
  - All other behaviour is identical.

## Test plan
- Reset defaults: assert reset_n=0 with INDEX_BITS=6, CTR_BITS=2 -> predict_taken=0 for every PC 0x0..0xFC, and both counters read 0.
- Saturation walk: 4 taken updates on idx 5 (PC 0x14) -> prediction sequence after each edge is 1,1,1,1 and the counter stays at 3. Then 4 not-taken updates -> predictions 1,0,0,0 and the counter stays at 0.
- Aliasing (bimodal): PCs 0x14 and 0x114 share idx 5 -> training 0x14 taken twice makes 0x114 predict 1.
- Same-cycle hazard: fetch_pc=0x14 while update_valid=1, idx 5, taken, from WNT -> predict_taken=0 that cycle and 1 the next cycle.
- Gshare (macro on, HIST_BITS=2): updates taken then not-taken -> ghr=2'b10; fetch_pc=0x14 -> predict_idx=6'h07.
- Counters: 10 updates with 3 where update_taken != update_pred_taken -> branch_cnt=10, mispredict_cnt=3. With CNT_BITS=4, after 20 updates branch_cnt=15 (saturated).
